// File: rtl/cfu_job_driver.sv
// CFU job driver: streams A and B words from a source memory into the CFU,
// issues GO, then reads every C row back (four words per row) into a
// destination memory. Exactly one CFU command is in flight at any time.
module cfu_job_driver #(
  parameter int unsigned SRC_AW = 16,
  parameter int unsigned DST_AW = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [14:0]       a_words,
  input  logic [13:0]       b_words,
  input  logic [12:0]       c_rows,
  input  logic [10:0]       k_dim,
  input  logic [11:0]       m_dim,
  input  logic [8:0]        n_dim,
  input  logic [31:0]       input_offset,
  input  logic [SRC_AW-1:0] a_base,
  input  logic [SRC_AW-1:0] b_base,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic              dst_wr_en,
  output logic [DST_AW-1:0] dst_addr,
  output logic [31:0]       dst_wdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [9:0]        cmd_payload_function_id,
  output logic [31:0]       cmd_payload_inputs_0,
  output logic [31:0]       cmd_payload_inputs_1,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [31:0]       rsp_payload_outputs_0
);

  localparam logic [9:0] OpWriteA = 10'd0;
  localparam logic [9:0] OpWriteB = 10'd8;
  localparam logic [9:0] OpReadC  = 10'd16;
  localparam logic [9:0] OpGo     = 10'd24;

  typedef enum logic [2:0] {
    StIdle, StRdA, StCmdA, StRdB, StCmdB, StGo, StRdC, StDone
  } state_e;

  state_e state_q, state_d;

  // Job parameters captured at start.
  logic [14:0]       a_words_q;
  logic [13:0]       b_words_q;
  logic [12:0]       c_rows_q;
  logic [31:0]       go_dims_q;
  logic [31:0]       offset_q;
  logic [SRC_AW-1:0] a_base_q, b_base_q;

  logic [14:0] a_idx_q, a_idx_d;
  logic [13:0] b_idx_q, b_idx_d;
  logic [12:0] row_q, row_d;
  logic [1:0]  word_q, word_d;
  logic        sent_q, sent_d;

  // fresh_q marks the first cycle of CMD_A/CMD_B, when src_rdata is live;
  // afterwards the captured copy keeps the payload steady across stalls.
  logic        fresh_q;
  logic [31:0] data_q;
  logic [31:0] rd_data;

  logic        dst_wr_en_q;
  logic [DST_AW-1:0] dst_addr_q;
  logic [31:0] dst_wdata_q;

  logic cmd_fire, rsp_fire;

  assign rd_data   = fresh_q ? src_rdata : data_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign dst_wr_en = dst_wr_en_q;
  assign dst_addr  = dst_addr_q;
  assign dst_wdata = dst_wdata_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  // A response only counts against a command that is issued or issuing now.
  assign rsp_fire  = rsp_valid && rsp_ready && (sent_q || cmd_fire);

  // Memory strobes and command payload decoded from state and counters.
  always_comb begin
    src_rd_en               = 1'b0;
    src_addr                = '0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    cmd_payload_function_id = 10'd0;
    cmd_payload_inputs_0    = 32'd0;
    cmd_payload_inputs_1    = 32'd0;
    case (state_q)
      StRdA: begin
        src_rd_en = 1'b1;
        src_addr  = a_base_q + SRC_AW'(a_idx_q);
      end
      StRdB: begin
        src_rd_en = 1'b1;
        src_addr  = b_base_q + SRC_AW'(b_idx_q);
      end
      StCmdA: begin
        cmd_valid               = !sent_q;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = OpWriteA;
        cmd_payload_inputs_0    = rd_data;
        cmd_payload_inputs_1    = {17'd0, a_idx_q};
      end
      StCmdB: begin
        cmd_valid               = !sent_q;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = OpWriteB;
        cmd_payload_inputs_0    = rd_data;
        cmd_payload_inputs_1    = {18'd0, b_idx_q};
      end
      StGo: begin
        cmd_valid               = !sent_q;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = OpGo;
        cmd_payload_inputs_0    = go_dims_q;
        cmd_payload_inputs_1    = offset_q;
      end
      StRdC: begin
        cmd_valid               = !sent_q;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = OpReadC;
        cmd_payload_inputs_0    = {30'd0, word_q};
        cmd_payload_inputs_1    = {19'd0, row_q};
      end
      default: ;
    endcase
  end

  // Next-state sequencing: each command phase advances on its response.
  always_comb begin
    state_d = state_q;
    a_idx_d = a_idx_q;
    b_idx_d = b_idx_q;
    row_d   = row_q;
    word_d  = word_q;
    if (rsp_fire) begin
      sent_d = 1'b0;
    end else if (cmd_fire) begin
      sent_d = 1'b1;
    end else begin
      sent_d = sent_q;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          a_idx_d = '0;
          b_idx_d = '0;
          row_d   = '0;
          word_d  = '0;
          if (a_words != 15'd0) begin
            state_d = StRdA;
          end else if (b_words != 14'd0) begin
            state_d = StRdB;
          end else begin
            state_d = StGo;
          end
        end
      end
      StRdA: state_d = StCmdA;
      StRdB: state_d = StCmdB;
      StCmdA: begin
        if (rsp_fire) begin
          if (a_idx_q == a_words_q - 15'd1) begin
            state_d = (b_words_q != 14'd0) ? StRdB : StGo;
          end else begin
            a_idx_d = a_idx_q + 15'd1;
            state_d = StRdA;
          end
        end
      end
      StCmdB: begin
        if (rsp_fire) begin
          if (b_idx_q == b_words_q - 14'd1) begin
            state_d = StGo;
          end else begin
            b_idx_d = b_idx_q + 14'd1;
            state_d = StRdB;
          end
        end
      end
      StGo: begin
        if (rsp_fire) begin
          state_d = (c_rows_q != 13'd0) ? StRdC : StDone;
        end
      end
      StRdC: begin
        if (rsp_fire) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            if (row_q == c_rows_q - 13'd1) begin
              state_d = StDone;
            end else begin
              row_d = row_q + 13'd1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, counters and outstanding-command flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_idx_q <= '0;
      b_idx_q <= '0;
      row_q   <= '0;
      word_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_idx_q <= a_idx_d;
      b_idx_q <= b_idx_d;
      row_q   <= row_d;
      word_q  <= word_d;
      sent_q  <= sent_d;
    end
  end

  // Datapath: job latch, read-data capture and registered destination write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_words_q   <= '0;
      b_words_q   <= '0;
      c_rows_q    <= '0;
      go_dims_q   <= '0;
      offset_q    <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      fresh_q     <= 1'b0;
      data_q      <= '0;
      dst_wr_en_q <= 1'b0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
    end else begin
      if ((state_q == StIdle) && start) begin
        a_words_q <= a_words;
        b_words_q <= b_words;
        c_rows_q  <= c_rows;
        go_dims_q <= {k_dim, m_dim, n_dim};
        offset_q  <= input_offset;
        a_base_q  <= a_base;
        b_base_q  <= b_base;
      end
      fresh_q <= (state_q == StRdA) || (state_q == StRdB);
      if (fresh_q) begin
        data_q <= src_rdata;
      end
      dst_wr_en_q <= rsp_fire && (state_q == StRdC);
      if (rsp_fire && (state_q == StRdC)) begin
        dst_addr_q  <= DST_AW'({row_q, word_q});
        dst_wdata_q <= rsp_payload_outputs_0;
      end
    end
  end

endmodule
